tdm_mux_4to1: RTL and testbench
===============================

# tdm_mux_4to1

Four-channel round-robin time-division multiplexer: the transmit-side counterpart of the 1-to-4 demultiplexer. It accepts words from four independent producers over valid/ready handshakes, serialises them onto one registered data lane, and tags each word with a 2-bit channel select and an enable. The output triple (`a`, `e`, `s`) drives the demultiplexer's `a`/`e`/`s` inputs directly, so the far end routes each word back to its original channel.

## Interface
- `W`, 8, data width of each channel and of the output lane

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  4  bit k: channel k presents a word
- `in_data`  in  4*W  channel k word at bits [k*W +: W]
- `in_ready`  out  4  bit k: channel k word accepted this cycle (one-hot or zero)
- `a`  out  W  registered output data
- `e`  out  1  registered output enable; 1 = `a`/`s` hold a valid word
- `s`  out  2  registered channel index of the word on `a`
- `out_ready`  in  1  downstream accepts the word on `a` this cycle

## Operation
- Internal state: output register (`a`, `e`, `s`) and round-robin pointer `last[1:0]` (channel granted most recently).
- Slot free condition: `free = !e || out_ready`.
- Arbitration (combinational): when `free` and not `rst`, scan channels `last+1`, `last+2`, `last+3`, `last+4` (mod 4). Grant the first channel with `in_valid` set. `in_ready` is one-hot on the granted channel, otherwise 0.
- When `free` is 0, `in_ready` = 0 and `a`/`e`/`s` hold their values exactly.
- Transfer on channel k (`in_valid[k] && in_ready[k]` at an edge):
  - `a` <= `in_data[k*W +: W]`
  - `s` <= k
  - `e` <= 1
  - `last` <= k
- When `free` and no channel is valid: `e` <= 0. `a` and `s` keep their previous values (don't-care while `e`=0). `last` is unchanged.
- A channel that drops `in_valid` before being granted loses nothing. The block never latches a word that was not handshaken.
- Fairness: with all four valid continuously and `out_ready`=1, grants follow 0,1,2,3,0,… No channel waits more than 3 grants.

## Timing
- Reset (`rst`=1 at an edge):
  - `a` = 0, `e` = 0, `s` = 2'b00, `last` = 2'b11 (so channel 0 has first priority).
  - `in_ready` is forced to 0 combinationally while `rst`=1.
- Latency: a word handshaken at edge N appears on `a`/`s` with `e`=1 immediately after edge N (1 cycle).
- Throughput: 1 word/cycle while `out_ready`=1.
- Back-to-back: the output word is consumed and a new word is accepted at the same edge, with no bubble.
- Backpressure: `e`=1 and `out_ready`=0 freezes the outputs and deasserts all `in_ready` in the same cycle.
- Reset mid-operation overrides everything. Any word in the output register is discarded, and no handshake completes at that edge.
- `out_ready` is ignored while `e`=0.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with all `in_valid`=1 -> `in_ready`=4'b0000, `a`=0, `e`=0, `s`=00. After release, the first grant is channel 0.
- Single channel (W=8): only ch2 valid with data 8'hA5, `out_ready`=1 -> `in_ready`=4'b0100 for one cycle. Next cycle `a`=8'hA5, `s`=2'b10, `e`=1. Once ch2 drops valid, `e`=0.
- Round-robin: all valid with data 8'h10/8'h21/8'h32/8'h43, `out_ready`=1 for 8 cycles -> `s` sequence 0,1,2,3,0,1,2,3 with matching `a`, and `e`=1 continuously.
- Backpressure: `out_ready`=0 for 3 cycles while `e`=1, `s`=01 -> `a`/`s` stable, `in_ready`=0. When `out_ready` returns to 1, the next grant is channel 2 (`last`=1).
- Skip and wrap: `last`=3, only ch1 and ch3 valid -> grants go ch1, ch3, ch1, … (`s`=01,11,01).
- Mid-stream reset: assert `rst` while `e`=1, `s`=11 -> next cycle `e`=0, `s`=00, `a`=0. After release, the first grant is ch0 if it is valid.

Source files
------------

// File: rtl/tdm_mux_4to1.sv
// tdm_mux_4to1
// Four-channel round-robin time-division multiplexer. Words from four
// valid/ready producers are serialised onto one registered lane. Each word
// is tagged with its channel index so a 1-to-4 demultiplexer can route it back.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   [3:0]     per-channel word present
//   in_data    in   [4*W-1:0] channel k word at bits [k*W +: W]
//   in_ready   out  [3:0]     one-hot grant (word accepted this cycle) or zero
//   a          out  [W-1:0]   registered output word
//   e          out            registered output enable (a/s valid)
//   s          out  [1:0]     registered channel index of the word on a
//   out_ready  in             downstream consumes the word on a this cycle
module tdm_mux_4to1 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     in_valid,
    input  logic [4*W-1:0] in_data,
    output logic [3:0]     in_ready,
    output logic [W-1:0]   a,
    output logic           e,
    output logic [1:0]     s,
    input  logic           out_ready
);

    logic [W-1:0] a_q, a_d;
    logic         e_q, e_d;
    logic [1:0]   s_q, s_d;
    logic [1:0]   last_q, last_d;

    logic [W-1:0] ch_data [4];
    logic         free;
    logic         grant_vld;
    logic [1:0]   grant_idx;
    logic [1:0]   cand;

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            ch_data[k] = in_data[k*W +: W];
        end
    end

    // The output slot can take a new word when empty or being drained now.
    assign free = !e_q || out_ready;

    // Scan last+1 .. last+4 (mod 4); the 2-bit wrap makes last+4 == last,
    // so the most recently granted channel has lowest priority.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_q;
        cand      = last_q;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!grant_vld && in_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (free && !rst && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        a_d    = a_q;
        e_d    = e_q;
        s_d    = s_q;
        last_d = last_q;
        if (free) begin
            if (grant_vld) begin
                a_d    = ch_data[grant_idx];
                s_d    = grant_idx;
                e_d    = 1'b1;
                last_d = grant_idx;
            end else begin
                e_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            e_q    <= 1'b0;
            s_q    <= 2'b00;
            last_q <= 2'b11;
        end else begin
            a_q    <= a_d;
            e_q    <= e_d;
            s_q    <= s_d;
            last_q <= last_d;
        end
    end

    assign a = a_q;
    assign e = e_q;
    assign s = s_q;

endmodule

// File: tb/tb_tdm_mux_4to1.sv
// Bench for tdm_mux_4to1: a table of hand-derived vectors plus a short
// hand-written sequence. Each vector checks in_ready combinationally before
// the edge. It also pushes the expected a/e/s to a queue, which is popped
// and compared after the edge.
module tb_tdm_mux_4to1;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic [W-1:0]   a;
    logic           e;
    logic [1:0]     s;
    logic           out_ready;

    tdm_mux_4to1 #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .a        (a),
        .e        (e),
        .s        (s),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  valid;
        logic        ordy;
        logic [31:0] data;
        logic [3:0]  exp_rdy;
        logic        exp_e;
        logic [1:0]  exp_s;
        logic [7:0]  exp_a;
    } vec_t;

    typedef struct packed {
        logic       e;
        logic [1:0] s;
        logic [7:0] a;
    } out_t;

    localparam logic [31:0] DA = 32'h4332_2110; // ch0=10 ch1=21 ch2=32 ch3=43
    localparam logic [31:0] DS = 32'h00A5_0000; // ch2=A5

    vec_t tbl [32];
    out_t sb_q [$];
    int   n_cmp = 0;
    int   n_mis = 0;

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic o,
                                input logic [31:0] d, input logic [3:0] er,
                                input logic ee, input logic [1:0] es, input logic [7:0] ea);
        vec_t t;
        t.rst = r; t.valid = v; t.ordy = o; t.data = d;
        t.exp_rdy = er; t.exp_e = ee; t.exp_s = es; t.exp_a = ea;
        return t;
    endfunction

    task automatic apply(input vec_t t, input string name);
        out_t exp_o;
        out_t got;
        @(negedge clk);
        rst       = t.rst;
        in_valid  = t.valid;
        out_ready = t.ordy;
        in_data   = t.data;
        #1;
        n_cmp++;
        if (in_ready !== t.exp_rdy) begin
            n_mis++;
            $display("FAIL %s in_ready: got %b expected %b", name, in_ready, t.exp_rdy);
        end
        sb_q.push_back('{e: t.exp_e, s: t.exp_s, a: t.exp_a});
        @(posedge clk);
        #1;
        exp_o = sb_q.pop_front();
        got   = '{e: e, s: s, a: a};
        n_cmp++;
        if (got !== exp_o) begin
            n_mis++;
            $display("FAIL %s out e/s/a: got %b/%b/%h expected %b/%b/%h",
                     name, e, s, a, exp_o.e, exp_o.s, exp_o.a);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;

        // reset held with all channels valid
        tbl[0]  = mk(1, 4'hF, 1, DA, 4'b0000, 0, 2'd0, 8'h00);
        tbl[1]  = mk(1, 4'hF, 1, DA, 4'b0000, 0, 2'd0, 8'h00);
        // round robin, 8 grants from channel 0
        tbl[2]  = mk(0, 4'hF, 1, DA, 4'b0001, 1, 2'd0, 8'h10);
        tbl[3]  = mk(0, 4'hF, 1, DA, 4'b0010, 1, 2'd1, 8'h21);
        tbl[4]  = mk(0, 4'hF, 1, DA, 4'b0100, 1, 2'd2, 8'h32);
        tbl[5]  = mk(0, 4'hF, 1, DA, 4'b1000, 1, 2'd3, 8'h43);
        tbl[6]  = mk(0, 4'hF, 1, DA, 4'b0001, 1, 2'd0, 8'h10);
        tbl[7]  = mk(0, 4'hF, 1, DA, 4'b0010, 1, 2'd1, 8'h21);
        tbl[8]  = mk(0, 4'hF, 1, DA, 4'b0100, 1, 2'd2, 8'h32);
        tbl[9]  = mk(0, 4'hF, 1, DA, 4'b1000, 1, 2'd3, 8'h43);
        // reach s=01, then 3 cycles of backpressure, then ch2 next
        tbl[10] = mk(0, 4'hF, 1, DA, 4'b0001, 1, 2'd0, 8'h10);
        tbl[11] = mk(0, 4'hF, 1, DA, 4'b0010, 1, 2'd1, 8'h21);
        tbl[12] = mk(0, 4'hF, 0, DA, 4'b0000, 1, 2'd1, 8'h21);
        tbl[13] = mk(0, 4'hF, 0, DA, 4'b0000, 1, 2'd1, 8'h21);
        tbl[14] = mk(0, 4'hF, 0, DA, 4'b0000, 1, 2'd1, 8'h21);
        tbl[15] = mk(0, 4'hF, 1, DA, 4'b0100, 1, 2'd2, 8'h32);
        // last=3, only ch1/ch3 valid: skip and wrap
        tbl[16] = mk(0, 4'hF, 1, DA, 4'b1000, 1, 2'd3, 8'h43);
        tbl[17] = mk(0, 4'hA, 1, DA, 4'b0010, 1, 2'd1, 8'h21);
        tbl[18] = mk(0, 4'hA, 1, DA, 4'b1000, 1, 2'd3, 8'h43);
        tbl[19] = mk(0, 4'hA, 1, DA, 4'b0010, 1, 2'd1, 8'h21);
        // single channel ch2=A5; out_ready ignored while e=0
        tbl[20] = mk(0, 4'h4, 1, DS, 4'b0100, 1, 2'd2, 8'hA5);
        tbl[21] = mk(0, 4'h0, 1, DS, 4'b0000, 0, 2'd2, 8'hA5);
        tbl[22] = mk(0, 4'h0, 0, DS, 4'b0000, 0, 2'd2, 8'hA5);
        tbl[23] = mk(0, 4'h4, 0, DS, 4'b0100, 1, 2'd2, 8'hA5);
        // mid-stream reset with s=11, then first grant ch0
        tbl[24] = mk(0, 4'h8, 1, DA, 4'b1000, 1, 2'd3, 8'h43);
        tbl[25] = mk(1, 4'hF, 1, DA, 4'b0000, 0, 2'd0, 8'h00);
        tbl[26] = mk(0, 4'hF, 1, DA, 4'b0001, 1, 2'd0, 8'h10);
        // reset while stalled discards the held word
        tbl[27] = mk(0, 4'hF, 0, DA, 4'b0000, 1, 2'd0, 8'h10);
        tbl[28] = mk(1, 4'hF, 0, DA, 4'b0000, 0, 2'd0, 8'h00);
        tbl[29] = mk(0, 4'hE, 1, DA, 4'b0010, 1, 2'd1, 8'h21);
        tbl[30] = mk(0, 4'h0, 0, DA, 4'b0000, 1, 2'd1, 8'h21);
        tbl[31] = mk(0, 4'h0, 1, DA, 4'b0000, 0, 2'd1, 8'h21);

        for (int i = 0; i < 32; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Hand sequence: ch1 raises valid only while the slot is stalled,
        // then withdraws; its word must never be latched. Pointer is 1 here.
        apply(mk(0, 4'h1, 1, DA, 4'b0001, 1, 2'd0, 8'h10), "drop_grant0");
        apply(mk(0, 4'h2, 0, DA, 4'b0000, 1, 2'd0, 8'h10), "drop_stall");
        apply(mk(0, 4'h0, 1, DA, 4'b0000, 0, 2'd0, 8'h10), "drop_gone");
        apply(mk(0, 4'h4, 1, DA, 4'b0100, 1, 2'd2, 8'h32), "drop_next");

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
